// File: rtl/instr_encoder_loader.sv
// Writer side of the instruction path: packs decoded ARM fields into 32-bit words,
// streams them into imem and holds the processor in reset until the program is loaded.
module instr_encoder_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W:0]   word_count_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       packed_next;
    logic              accept, illegal, full, write_ok, restart;

    assign accept   = in_valid && (state_reg == S_LOAD);
    assign illegal  = (in_op == 2'b11);
    assign full     = (word_count_reg == DEPTH_C);
    assign write_ok = accept && !illegal && !full;
    // start only matters outside LOAD/FLUSH; a start pulse mid-load is ignored
    assign restart  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                (state_reg == S_ERROR));

    always_comb begin
        if (in_op == 2'b10) begin
            packed_next = {in_cond, 2'b10, in_funct[5:4], in_imm24};
        end else begin
            packed_next = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (illegal || full) state_next = S_ERROR;
                    else if (in_last)    state_next = S_FLUSH;
                end
            end
            S_FLUSH: state_next = S_DONE;
            S_DONE:  if (start) state_next = S_LOAD;
            S_ERROR: if (start) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    // word_count advances on the same edge that raises imem_we, so it always
    // equals the number of writes issued so far in this load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            word_count_reg <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= write_ok;
            if (write_ok) begin
                addr_reg       <= word_count_reg[ADDR_W-1:0];
                wdata_reg      <= packed_next;
                word_count_reg <= word_count_reg + 1'b1;
            end else if (restart) begin
                word_count_reg <= '0;
            end
        end
    end

    assign in_ready   = (state_reg == S_LOAD);
    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_hold   = (state_reg != S_DONE);
    assign done       = (state_reg == S_DONE);
    assign error      = (state_reg == S_ERROR);
    assign word_count = word_count_reg;

endmodule
